// File: rtl/seq_mantissa_multiplier_pkg.sv
// Shared types and constants for the sequential mantissa multiplier.
// State encodings are fixed; the unused code 2'd3 is treated as IDLE by the FSM.
package seq_mantissa_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // FP32 mantissa geometry used by the enclosing FP multiply path.
  localparam int MANT_W = 24;
  localparam int PROD_W = 48;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_mantissa_multiplier_pp_group.sv
// Combinational partial product of a small multiplier group and a wide multiplicand,
// built as a sum of conditionally selected shifted copies of the multiplicand.
module mult_pp_group #(
  parameter int WIDTH          = 24,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]        i_mcand,
  input  logic [BITS_PER_CYCLE-1:0] i_grp,
  output logic [2*WIDTH-1:0]        o_pp
);

  always_comb begin
    // NOTE: assign a default before the loop so no path leaves o_pp unassigned (no latch).
    o_pp = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (i_grp[k]) o_pp = o_pp + (i_mcand << k);
    end
  end

endmodule

// File: rtl/seq_mantissa_multiplier.sv
// Multi-cycle unsigned shift-add multiplier retiring BITS_PER_CYCLE multiplier bits
// per clock, with valid/ready handshakes and optional early exit on a zero multiplier.
module seq_mantissa_multiplier
  import seq_mantissa_multiplier_pkg::*;
#(
  parameter int WIDTH          = 24,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit EARLY_EXIT     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(N);

  if (BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
    $fatal(1, "seq_mantissa_multiplier: BITS_PER_CYCLE must divide WIDTH");
  end

  state_e               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_out;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [2*WIDTH-1:0]   w_pp;
  logic [2*WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]     w_mplier_next;
  logic                 w_last;
  logic                 w_accept;

  mult_pp_group #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_pp_group (
    .i_mcand (r_mcand),
    .i_grp   (r_mplier[BITS_PER_CYCLE-1:0]),
    .o_pp    (w_pp)
  );

  assign w_sum         = r_acc + w_pp;
  assign w_mplier_next = r_mplier >> BITS_PER_CYCLE;
  assign w_last        = (r_cnt == '0) || (EARLY_EXIT && (w_mplier_next == '0));

  // DONE lets a new operand pair in on the same edge the product is consumed.
  assign in_ready = (r_state == ST_CALC) ? 1'b0 :
                    (r_state == ST_DONE) ? out_ready : 1'b1;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_accept) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state     <= ST_CALC;
      r_mcand     <= {{WIDTH{1'b0}}, a};
      r_mplier    <= b;
      r_acc       <= '0;
      r_cnt       <= CW'(N - 1);
      r_out_valid <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        ST_CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= w_mplier_next;
          r_cnt    <= r_cnt - 1'b1;
          if (w_last) begin
            r_out       <= w_sum;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out       = r_out;

endmodule

// File: tb/tb_seq_mantissa_multiplier.sv
// Directed bench for seq_mantissa_multiplier: three configurations share one stimulus
// stream; each step checks the instance whose configuration it targets.
module tb_seq_mantissa_multiplier;

  localparam int W = 24;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           out_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;

  // d1: 1 bit/cycle, d4: 4 bits/cycle, de: 1 bit/cycle with early exit
  logic           d1_in_ready, d1_out_valid, d1_busy;
  logic [2*W-1:0] d1_out;
  logic           d4_in_ready, d4_out_valid, d4_busy;
  logic [2*W-1:0] d4_out;
  logic           de_in_ready, de_out_valid, de_busy;
  logic [2*W-1:0] de_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_mantissa_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(1), .EARLY_EXIT(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d1_in_ready),
    .a(a), .b(b), .out_valid(d1_out_valid), .out_ready(out_ready),
    .out(d1_out), .busy(d1_busy));

  seq_mantissa_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(4), .EARLY_EXIT(1'b0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d4_in_ready),
    .a(a), .b(b), .out_valid(d4_out_valid), .out_ready(out_ready),
    .out(d4_out), .busy(d4_busy));

  seq_mantissa_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(1), .EARLY_EXIT(1'b1)) u_de (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(de_in_ready),
    .a(a), .b(b), .out_valid(de_out_valid), .out_ready(out_ready),
    .out(de_out), .busy(de_busy));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_valid(input int w);
    case (w)
      1:       return d1_out_valid;
      4:       return d4_out_valid;
      default: return de_out_valid;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      1:       return d1_busy;
      4:       return d4_busy;
      default: return de_busy;
    endcase
  endfunction

  // Called just after the accept edge; returns cycles until out_valid and busy-cycle count.
  task automatic wait_done(input int w, output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (!get_valid(w) && cyc < 200) begin
      if (get_busy(w)) busy_cyc++;
      step();
      cyc++;
    end
  endtask

  task automatic reset_pulse();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bcyc;
    logic [2*W-1:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    step();
    check("reset_in_ready",  {63'd0, d1_in_ready},  64'd1);
    check("reset_out_valid", {63'd0, d1_out_valid}, 64'd0);
    check("reset_busy",      {63'd0, d1_busy},      64'd0);
    check("reset_out",       {16'd0, d1_out},       64'd0);
    rst_n = 1'b1;
    step();

    // 1: full-scale operands, 1 bit per cycle
    a = 24'hFFFFFF; b = 24'hFFFFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_busy_after_accept", {63'd0, d1_busy}, 64'd1);
    wait_done(1, cyc, bcyc);
    check("t1_latency",   cyc,  24);
    check("t1_busy_cycs", bcyc, 24);
    check("t1_out", {16'd0, d1_out}, 64'hFFFFFE000001);
    step();
    check("t1_idle_in_ready", {63'd0, d1_in_ready}, 64'd1);
    check("t1_out_held_idle", {16'd0, d1_out}, 64'hFFFFFE000001);

    // 2: 1.5 * 1.5 with 4 bits per cycle
    reset_pulse();
    a = 24'hC00000; b = 24'hC00000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(4, cyc, bcyc);
    check("t2_latency", cyc, 6);
    check("t2_out", {16'd0, d4_out}, 64'h900000000000);

    // 3: early exit with b=1, then b=0 back-to-back
    reset_pulse();
    a = 24'hABCDEF; b = 24'h000001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(5, cyc, bcyc);
    check("t3_ee_latency_b1", cyc, 1);
    check("t3_ee_out_b1", {16'd0, de_out}, 64'h000000ABCDEF);
    b = 24'h000000; in_valid = 1'b1;
    #1;
    check("t3_done_in_ready", {63'd0, de_in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check("t3_b2b_valid_drop", {63'd0, de_out_valid}, 64'd0);
    wait_done(5, cyc, bcyc);
    check("t3_ee_latency_b0", cyc, 1);
    check("t3_ee_out_b0", {16'd0, de_out}, 64'd0);

    // 4: backpressure in DONE, then accept on the consume edge
    reset_pulse();
    out_ready = 1'b0;
    a = 24'h001234; b = 24'h000010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(1, cyc, bcyc);
    check("t4_latency", cyc, 24);
    held = 48'h000000012340;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_out",      {16'd0, d1_out},       {16'd0, held});
      check("t4_hold_valid",    {63'd0, d1_out_valid}, 64'd1);
      check("t4_hold_in_ready", {63'd0, d1_in_ready},  64'd0);
      step();
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 24'd3; b = 24'd5;
    #1;
    check("t4_in_ready_follows", {63'd0, d1_in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check("t4_accept_busy",  {63'd0, d1_busy},      64'd1);
    check("t4_accept_valid", {63'd0, d1_out_valid}, 64'd0);
    check("t4_out_kept",     {16'd0, d1_out},       {16'd0, held});
    wait_done(1, cyc, bcyc);
    check("t4_second_latency", cyc, 24);
    check("t4_second_out", {16'd0, d1_out}, 64'd15);

    // 5: in_valid pulsed mid-CALC with different operands
    reset_pulse();
    a = 24'h000ABC; b = 24'h000123; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    a = 24'hFFFFFF; b = 24'hFFFFFF; in_valid = 1'b1;
    check("t5_calc_in_ready", {63'd0, d1_in_ready}, 64'd0);
    step();
    step();
    in_valid = 1'b0;
    a = '0; b = '0;
    wait_done(1, cyc, bcyc);
    check("t5_latency", cyc + 7, 24);
    check("t5_out", {16'd0, d1_out}, 64'h0000000C33B4);

    // 6: reset during cycle 10 of a 24-cycle op, then a fresh op
    step();
    a = 24'hFFFFFF; b = 24'hFFFFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("t6_busy_before_rst", {63'd0, d1_busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_in_ready",  {63'd0, d1_in_ready},  64'd1);
    check("t6_rst_out_valid", {63'd0, d1_out_valid}, 64'd0);
    check("t6_rst_busy",      {63'd0, d1_busy},      64'd0);
    check("t6_rst_out",       {16'd0, d1_out},       64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_no_stale_valid", {63'd0, d1_out_valid}, 64'd0);
    a = 24'd2; b = 24'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_done(1, cyc, bcyc);
    check("t6_latency", cyc, 24);
    check("t6_out", {16'd0, d1_out}, 64'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
